// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the IF-stage PC; updates from ID-stage resolution land on the next edge.
module branch_target_predictor #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8,
  parameter int CNT_BITS   = 2,
  parameter int PERF_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_all_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              hit_o,
  output logic              predict_taken_o,
  output logic [ADDR_W-1:0] predict_target_o,
  input  logic              update_valid_i,
  input  logic [ADDR_W-1:0] update_pc_i,
  input  logic              update_taken_i,
  input  logic [ADDR_W-1:0] update_target_i,
  output logic [PERF_W-1:0] update_count_o,
  output logic [PERF_W-1:0] mispredict_count_o
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(2 ** (CNT_BITS - 1));
  localparam logic [PERF_W-1:0]   PERF_MAX = {PERF_W{1'b1}};

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
  logic [CNT_BITS-1:0] cnt_d    [ENTRIES];
  logic [ADDR_W-1:0]   target_q [ENTRIES];
  logic [ADDR_W-1:0]   target_d [ENTRIES];

  logic [PERF_W-1:0] upd_count_q, upd_count_d;
  logic [PERF_W-1:0] mis_count_q, mis_count_d;

  logic [INDEX_BITS-1:0] lk_idx, up_idx;
  logic [TAG_BITS-1:0]   lk_tag, up_tag;
  logic                  up_hit, up_pred, up_mis;
  logic                  unused_pc_bits;

  assign lk_idx = lookup_pc_i[TAG_LO-1:2];
  assign lk_tag = lookup_pc_i[TAG_HI:TAG_LO];
  assign up_idx = update_pc_i[TAG_LO-1:2];
  assign up_tag = update_pc_i[TAG_HI:TAG_LO];

  // Only the index and tag fields identify a branch; the rest of the update PC is ignored.
  assign unused_pc_bits = ^{update_pc_i[1:0], update_pc_i[ADDR_W-1:TAG_HI+1]};

  // Lookup sees pre-edge table state only, so an update to the same entry appears a cycle later.
  always_comb begin
    hit_o            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predict_taken_o  = hit_o && cnt_q[lk_idx][CNT_BITS-1];
    predict_target_o = predict_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);
  end

  always_comb begin
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_pred = up_hit && cnt_q[up_idx][CNT_BITS-1];
    up_mis  = (up_pred != update_taken_i) ||
              (up_pred && (target_q[up_idx] != update_target_i));
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_comb begin
        valid_d[gi]  = valid_q[gi];
        tag_d[gi]    = tag_q[gi];
        cnt_d[gi]    = cnt_q[gi];
        target_d[gi] = target_q[gi];
        if (flush_all_i) begin
          // Flush only drops validity; stale fields are harmless once invalid.
          valid_d[gi] = 1'b0;
        end else if (update_valid_i && (up_idx == INDEX_BITS'(gi))) begin
          if (up_hit) begin
            if (update_taken_i) begin
              cnt_d[gi]    = (cnt_q[gi] == CNT_MAX) ? cnt_q[gi] : cnt_q[gi] + CNT_BITS'(1);
              target_d[gi] = update_target_i;
            end else begin
              cnt_d[gi] = (cnt_q[gi] == '0) ? cnt_q[gi] : cnt_q[gi] - CNT_BITS'(1);
            end
          end else if (update_taken_i) begin
            valid_d[gi]  = 1'b1;
            tag_d[gi]    = up_tag;
            cnt_d[gi]    = CNT_WEAK;
            target_d[gi] = update_target_i;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q[gi]  <= 1'b0;
          tag_q[gi]    <= '0;
          cnt_q[gi]    <= '0;
          target_q[gi] <= '0;
        end else begin
          valid_q[gi]  <= valid_d[gi];
          tag_q[gi]    <= tag_d[gi];
          cnt_q[gi]    <= cnt_d[gi];
          target_q[gi] <= target_d[gi];
        end
      end
    end
  endgenerate

  // Perf counters still observe updates that a concurrent flush keeps out of the table.
  always_comb begin
    upd_count_d = upd_count_q;
    mis_count_d = mis_count_q;
    if (update_valid_i) begin
      if (upd_count_q != PERF_MAX) upd_count_d = upd_count_q + PERF_W'(1);
      if (up_mis && (mis_count_q != PERF_MAX)) mis_count_d = mis_count_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      upd_count_q <= '0;
      mis_count_q <= '0;
    end else begin
      upd_count_q <= upd_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign update_count_o     = upd_count_q;
  assign mispredict_count_o = mis_count_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomised and directed checks of branch_target_predictor against a table model
// built from plain integer arithmetic; a PERF_W=4 copy shares the stimulus to exercise perf saturation.
module tb_branch_target_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_all_i, update_valid_i, update_taken_i;
  logic [31:0] lookup_pc_i, update_pc_i, update_target_i;
  logic        hit_o, predict_taken_o;
  logic [31:0] predict_target_o;
  logic [15:0] update_count_o, mispredict_count_o;
  logic        s_hit, s_taken;
  logic [31:0] s_target;
  logic [3:0]  s_upd, s_mis;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  branch_target_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_all_i(flush_all_i), .lookup_pc_i(lookup_pc_i),
    .hit_o(hit_o), .predict_taken_o(predict_taken_o), .predict_target_o(predict_target_o),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
    .update_target_i(update_target_i), .update_count_o(update_count_o),
    .mispredict_count_o(mispredict_count_o)
  );

  branch_target_predictor #(.PERF_W(4)) dut_p4 (
    .clk_i(clk_i), .rst_i(rst_i), .flush_all_i(flush_all_i), .lookup_pc_i(lookup_pc_i),
    .hit_o(s_hit), .predict_taken_o(s_taken), .predict_target_o(s_target),
    .update_valid_i(update_valid_i), .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
    .update_target_i(update_target_i), .update_count_o(s_upd), .mispredict_count_o(s_mis)
  );

  // Reference model: 16 entries, counter 0..3, taken when counter >= 2.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int          m_cnt   [16];
  logic [31:0] m_tgt   [16];
  longint      m_upd = 0;
  longint      m_mis = 0;

  function automatic int unsigned f_idx(logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic int unsigned f_tag(logic [31:0] pc);
    return (pc / 64) % 256;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[f_idx(pc)] && (m_tag[f_idx(pc)] == f_tag(pc));
  endfunction

  function automatic bit m_taken(logic [31:0] pc);
    return m_hit(pc) && (m_cnt[f_idx(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_target(logic [31:0] pc);
    return m_taken(pc) ? m_tgt[f_idx(pc)] : pc + 32'd4;
  endfunction

  function automatic longint sat(longint v, longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic set_in(input bit rst, input bit flush, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    rst_i = rst; flush_all_i = flush; lookup_pc_i = lpc;
    update_valid_i = uv; update_pc_i = upc; update_taken_i = ut; update_target_i = utgt;
  endtask

  // Advance one edge and apply the same edge to the model, using pre-edge model state.
  task automatic tick();
    int unsigned i;
    bit h, pred, mis;
    @(posedge clk_i);
    if (rst_i) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_cnt[k] = 0; m_tgt[k] = 0;
      end
      m_upd = 0; m_mis = 0;
    end else begin
      if (update_valid_i) begin
        i    = f_idx(update_pc_i);
        h    = m_hit(update_pc_i);
        pred = h && (m_cnt[i] >= 2);
        mis  = (pred != update_taken_i) || (pred && (m_tgt[i] != update_target_i));
        m_upd++;
        if (mis) m_mis++;
        if (!flush_all_i) begin
          if (h && update_taken_i) begin
            m_cnt[i] = (m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1;
            m_tgt[i] = update_target_i;
          end else if (h) begin
            m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
          end else if (update_taken_i) begin
            m_valid[i] = 1; m_tag[i] = f_tag(update_pc_i);
            m_tgt[i] = update_target_i; m_cnt[i] = 2;
          end
        end
      end
      if (flush_all_i) for (int k = 0; k < 16; k++) m_valid[k] = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    set_in(1, 0, 32'h40, 0, 0, 0, 0);
    tick(); tick();
    set_in(0, 0, 32'h40, 0, 0, 0, 0);
    @(negedge clk_i);
    n_tests++; if (hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit_o); end
    n_tests++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", predict_taken_o); end
    n_tests++; if (predict_target_o !== 32'h44) begin n_fail++; $display("FAIL reset_target: got %h want 00000044", predict_target_o); end
    n_tests++; if (update_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_upd: got %0d want 0", update_count_o); end
    n_tests++; if (mispredict_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_mis: got %0d want 0", mispredict_count_o); end
    $display("[TB] reset: hit=%b taken=%b target=%h", hit_o, predict_taken_o, predict_target_o);
  endtask

  task automatic test_allocate();
    set_in(0, 0, 32'h40, 1, 32'h40, 1, 32'h100);
    tick();
    set_in(0, 0, 32'h40, 0, 0, 0, 0);
    @(negedge clk_i);
    n_tests++; if (hit_o !== 1'b1) begin n_fail++; $display("FAIL alloc_hit: got %b want 1", hit_o); end
    n_tests++; if (predict_taken_o !== 1'b1) begin n_fail++; $display("FAIL alloc_taken: got %b want 1", predict_taken_o); end
    n_tests++; if (predict_target_o !== 32'h100) begin n_fail++; $display("FAIL alloc_target: got %h want 00000100", predict_target_o); end
    n_tests++; if (update_count_o !== 16'd1) begin n_fail++; $display("FAIL alloc_upd: got %0d want 1", update_count_o); end
    n_tests++; if (mispredict_count_o !== 16'd1) begin n_fail++; $display("FAIL alloc_mis: got %0d want 1", mispredict_count_o); end
    $display("[TB] allocate 0x40->0x100: hit=%b taken=%b target=%h", hit_o, predict_taken_o, predict_target_o);
  endtask

  task automatic test_saturation();
    bit taken_exp;
    for (int k = 0; k < 5; k++) begin
      set_in(0, 0, 32'h40, 1, 32'h40, k < 3, 32'h100);
      tick();
      set_in(0, 0, 32'h40, 0, 0, 0, 0);
      @(negedge clk_i);
      taken_exp = (k < 4);
      n_tests++; if (hit_o !== 1'b1) begin n_fail++; $display("FAIL sat_hit[%0d]: got %b want 1", k, hit_o); end
      n_tests++; if (predict_taken_o !== taken_exp) begin n_fail++; $display("FAIL sat_taken[%0d]: got %b want %b", k, predict_taken_o, taken_exp); end
      $display("[TB] saturation step %0d taken_in=%0d: hit=%b pred_taken=%b", k, k < 3, hit_o, predict_taken_o);
    end
    n_tests++; if (predict_target_o !== 32'h44) begin n_fail++; $display("FAIL sat_target: got %h want 00000044", predict_target_o); end
    n_tests++; if (update_count_o !== 16'd6) begin n_fail++; $display("FAIL sat_upd: got %0d want 6", update_count_o); end
    n_tests++; if (mispredict_count_o !== 16'd3) begin n_fail++; $display("FAIL sat_mis: got %0d want 3", mispredict_count_o); end
  endtask

  task automatic test_conflict();
    set_in(0, 0, 32'h40, 1, 32'h80, 1, 32'h200);
    tick();
    @(negedge clk_i);
    set_in(0, 0, 32'h40, 0, 0, 0, 0);
    #1;
    n_tests++; if (hit_o !== 1'b0) begin n_fail++; $display("FAIL conflict_old_hit: got %b want 0", hit_o); end
    n_tests++; if (predict_target_o !== 32'h44) begin n_fail++; $display("FAIL conflict_old_target: got %h want 00000044", predict_target_o); end
    lookup_pc_i = 32'h80;
    #1;
    n_tests++; if (hit_o !== 1'b1) begin n_fail++; $display("FAIL conflict_new_hit: got %b want 1", hit_o); end
    n_tests++; if (predict_target_o !== 32'h200) begin n_fail++; $display("FAIL conflict_new_target: got %h want 00000200", predict_target_o); end
    $display("[TB] conflict 0x80 evicts 0x40: hit(0x80)=%b target=%h", hit_o, predict_target_o);
  endtask

  task automatic test_same_cycle();
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 32'h80, 1, 32'h80, 1, 32'h300);
    @(negedge clk_i);
    n_tests++; if (hit_o !== 1'b0) begin n_fail++; $display("FAIL same_cycle_hit: got %b want 0", hit_o); end
    tick();
    set_in(0, 1, 32'h80, 1, 32'hC0, 1, 32'h400);
    @(negedge clk_i);
    n_tests++; if (hit_o !== 1'b1) begin n_fail++; $display("FAIL next_cycle_hit: got %b want 1", hit_o); end
    n_tests++; if (predict_target_o !== 32'h300) begin n_fail++; $display("FAIL next_cycle_target: got %h want 00000300", predict_target_o); end
    tick();
    set_in(0, 0, 32'h80, 0, 0, 0, 0);
    @(negedge clk_i);
    n_tests++; if (hit_o !== 1'b0) begin n_fail++; $display("FAIL flush_old_hit: got %b want 0", hit_o); end
    lookup_pc_i = 32'hC0;
    #1;
    n_tests++; if (hit_o !== 1'b0) begin n_fail++; $display("FAIL flush_dropped_hit: got %b want 0", hit_o); end
    n_tests++; if (update_count_o !== 16'd2) begin n_fail++; $display("FAIL flush_upd: got %0d want 2", update_count_o); end
    $display("[TB] same-cycle/flush: hit(0xC0)=%b upd=%0d", hit_o, update_count_o);
  endtask

  task automatic test_perf_sat();
    set_in(1, 0, 0, 0, 0, 0, 0);
    tick();
    // Alternating directions at one PC mispredict every time once allocated.
    for (int k = 0; k < 20; k++) begin
      set_in(0, 0, 32'h40, 1, 32'h40, (k % 2) == 0, 32'h100);
      tick();
    end
    n_tests++; if (s_mis !== 4'd15) begin n_fail++; $display("FAIL perf_sat_mis4: got %0d want 15", s_mis); end
    n_tests++; if (s_upd !== 4'd15) begin n_fail++; $display("FAIL perf_sat_upd4: got %0d want 15", s_upd); end
    n_tests++; if (mispredict_count_o !== 16'd20) begin n_fail++; $display("FAIL perf_mis16: got %0d want 20", mispredict_count_o); end
    $display("[TB] perf saturation: mis4=%0d upd4=%0d mis16=%0d", s_mis, s_upd, mispredict_count_o);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = (($urandom % 4) * 64) + (($urandom % 16) * 4) + ($urandom % 4);
    if ($urandom % 8 == 0) pc = pc + (($urandom % 4) << 16);
    return pc;
  endfunction

  task automatic test_random();
    logic [31:0] lpc;
    for (int n = 0; n < 400; n++) begin
      lpc = rand_pc();
      set_in(($urandom % 64) == 0, ($urandom % 32) == 0, lpc, $urandom % 2,
             ($urandom % 2) ? lpc : rand_pc(), $urandom % 2, ($urandom % 2) ? 32'h1000 : 32'h2000);
      @(negedge clk_i);
      n_tests++; if (hit_o !== m_hit(lpc)) begin n_fail++; $display("FAIL rnd_hit[%0d] pc=%h: got %b want %b", n, lpc, hit_o, m_hit(lpc)); end
      n_tests++; if (predict_taken_o !== m_taken(lpc)) begin n_fail++; $display("FAIL rnd_taken[%0d] pc=%h: got %b want %b", n, lpc, predict_taken_o, m_taken(lpc)); end
      n_tests++; if (predict_target_o !== m_target(lpc)) begin n_fail++; $display("FAIL rnd_target[%0d] pc=%h: got %h want %h", n, lpc, predict_target_o, m_target(lpc)); end
      $display("[TB] rnd %0d rst=%b fl=%b lpc=%h uv=%b upc=%h ut=%b hit=%b tk=%b tgt=%h", n, rst_i,
               flush_all_i, lpc, update_valid_i, update_pc_i, update_taken_i, hit_o, predict_taken_o, predict_target_o);
      tick();
      n_tests++; if (update_count_o !== 16'(sat(m_upd, 65535))) begin n_fail++; $display("FAIL rnd_upd[%0d]: got %0d want %0d", n, update_count_o, sat(m_upd, 65535)); end
      n_tests++; if (mispredict_count_o !== 16'(sat(m_mis, 65535))) begin n_fail++; $display("FAIL rnd_mis[%0d]: got %0d want %0d", n, mispredict_count_o, sat(m_mis, 65535)); end
      n_tests++; if (s_upd !== 4'(sat(m_upd, 15))) begin n_fail++; $display("FAIL rnd_upd4[%0d]: got %0d want %0d", n, s_upd, sat(m_upd, 15)); end
      n_tests++; if (s_mis !== 4'(sat(m_mis, 15))) begin n_fail++; $display("FAIL rnd_mis4[%0d]: got %0d want %0d", n, s_mis, sat(m_mis, 15)); end
    end
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_allocate();
    test_saturation();
    test_conflict();
    test_same_cycle();
    test_perf_sat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
